// File: rtl/joybus_poll_sched_if.sv
// JOYBUS transceiver handshake bundle between the poll scheduler (master)
// and the TX/RX pair (slave). The scheduler owns tx_start, tx_cmd and rx_start.
interface joybus_poll_sched_if;
    logic        tx_start;
    logic [7:0]  tx_cmd;
    logic        tx_done;
    logic        rx_start;
    logic        rx_done;
    logic [7:0]  rx_status;
    logic [31:0] rx_data;

    modport master (
        output tx_start, tx_cmd, rx_start,
        input  tx_done, rx_done, rx_status, rx_data
    );

    modport slave (
        input  tx_start, tx_cmd, rx_start,
        output tx_done, rx_done, rx_status, rx_data
    );
endinterface

// File: rtl/joybus_poll_sched.sv
// JOYBUS poll scheduler: issues one poll transaction per POLL_PERIOD cycles
// (or on poll_now), hands the line from TX to RX, waits for rx_done or a
// timeout, latches the 40-bit response and reports ok/timeout to the host.
// Optional build macro: POLL_RETRY_EN -- the first timeout of a transaction
// silently restarts it; only a second consecutive timeout is reported.
// Pulse timing: tx_start/rx_start/busy decode the state directly, so
// rx_start lands in the tx_done cycle. poll_ok and poll_timeout are
// registered: they appear one cycle after rx_done, or one cycle after the
// RX_TIMEOUT-th RX_WAIT cycle (count == RX_TIMEOUT-1).
module joybus_poll_sched #(
    parameter int         POLL_PERIOD = 416667,
    parameter int         RX_TIMEOUT  = 5000,
    parameter logic [7:0] POLL_CMD    = 8'h01
) (
    input  logic                clk,
    input  logic                rst_n,
    joybus_poll_sched_if.master bus,
    input  logic                enable,
    input  logic                poll_now,
    output logic [7:0]          cntlr_status,
    output logic [31:0]         cntlr_data,
    output logic                poll_ok,
    output logic                poll_timeout,
    output logic [7:0]          err_cnt,
    output logic                busy
);

    localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TW = (RX_TIMEOUT > 0) ? $clog2(RX_TIMEOUT + 1) : 1;
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(RX_TIMEOUT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] TX_WAIT = 3'd2;
    localparam logic [2:0] RX_WAIT = 3'd3;
    localparam logic [2:0] HOLD    = 3'd4;

    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [PW-1:0] period_cnt_reg;
    logic [TW-1:0] timeout_cnt_reg;
    logic          rx_ok;
    logic          timeout_hit;
    logic          timeout_report;

`ifdef POLL_RETRY_EN
    logic retry_reg;
    logic retry_now;
    assign retry_now      = timeout_hit & ~retry_reg;
    assign timeout_report = timeout_hit &  retry_reg;
`else
    assign timeout_report = timeout_hit;
`endif

    assign bus.tx_start = (state_reg == START);
    assign bus.tx_cmd   = POLL_CMD;
    assign bus.rx_start = (state_reg == TX_WAIT) && bus.tx_done;
    assign busy         = (state_reg == TX_WAIT) || (state_reg == RX_WAIT);

    // Next-state decode; rx_done is checked before the timeout so it wins a tie
    always_comb begin
        state_next  = state_reg;
        rx_ok       = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable || poll_now)
                    state_next = START;
            end
            START: begin
                state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.tx_done)
                    state_next = RX_WAIT;
            end
            RX_WAIT: begin
                if (bus.rx_done) begin
                    rx_ok      = 1'b1;
                    state_next = HOLD;
                end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
`ifdef POLL_RETRY_EN
                    state_next  = retry_reg ? HOLD : START;
`else
                    state_next  = HOLD;
`endif
                end
            end
            HOLD: begin
                // poll_now re-bases the period; a saturated counter means
                // the transaction overran, so the next poll starts at once
                if (poll_now)
                    state_next = START;
                else if (!enable)
                    state_next = IDLE;
                else if (period_cnt_reg == PERIOD_LAST)
                    state_next = START;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Period counter: zero in the START cycle, saturates at POLL_PERIOD-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            period_cnt_reg <= '0;
        else if (state_next == START)
            period_cnt_reg <= '0;
        else if (period_cnt_reg != PERIOD_LAST)
            period_cnt_reg <= period_cnt_reg + 1'b1;
    end

    // Timeout counter: cleared with rx_start, counts RX_WAIT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            timeout_cnt_reg <= '0;
        else if ((state_reg == TX_WAIT) && bus.tx_done)
            timeout_cnt_reg <= '0;
        else if ((state_reg == RX_WAIT) && (timeout_cnt_reg != TIMEOUT_LAST))
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
    end

    // Host-side results: latch whole response at once, saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_ok      <= 1'b0;
            poll_timeout <= 1'b0;
            cntlr_status <= 8'h00;
            cntlr_data   <= 32'h0;
            err_cnt      <= 8'h00;
        end else begin
            poll_ok      <= rx_ok;
            poll_timeout <= timeout_report;
            if (rx_ok) begin
                cntlr_status <= bus.rx_status;
                cntlr_data   <= bus.rx_data;
                err_cnt      <= 8'h00;
            end else if (timeout_report && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

`ifdef POLL_RETRY_EN
    // Retry flag: set by the silent first timeout, cleared by success or a fresh poll
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retry_reg <= 1'b0;
        else if (rx_ok)
            retry_reg <= 1'b0;
        else if (retry_now)
            retry_reg <= 1'b1;
        else if (((state_reg == IDLE) || (state_reg == HOLD)) && (state_next == START))
            retry_reg <= 1'b0;
    end
`endif

endmodule
